// File: rtl/dff_pipe.sv
// dff_pipe: parametrised register pipeline of DEPTH stages, each WIDTH bits,
// with per-stage valid bits and valid/ready handshakes at both ends.
// Bubbles collapse: a word moves forward whenever the stage ahead of it is
// empty or is itself moving, so a stalled output lets upstream stages fill.
// out_valid, out_data and count come straight from registers. in_ready has a
// combinational path from out_ready through the ready chain.
module dff_pipe #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Stage state; index DEPTH-1 is the output stage.
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CNT_W-1:0] count_q;

  // Per-stage movement and next-state signals.
  logic [DEPTH-1:0] adv;        // stage k hands its word onward this cycle
  logic [DEPTH-1:0] load;       // stage k receives a word this cycle
  logic [WIDTH-1:0] src [DEPTH]; // word that would move into stage k
  logic [DEPTH-1:0] valid_d;
  logic [CNT_W-1:0] count_d;
  logic             stage0_rdy;
  logic             in_fire;

  // Ready/advance chain, walked from the output stage back to the input stage.
  always_comb begin
    logic rdy_ahead;
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    adv       = '0;
    rdy_ahead = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k]    = valid_q[k] & rdy_ahead;
      rdy_ahead = ~valid_q[k] | adv[k];
    end
    stage0_rdy = rdy_ahead;
  end

  assign in_ready = stage0_rdy & ~flush;
  assign in_fire  = in_valid & in_ready;

  // Which stages receive a word, and from where.
  always_comb begin
    load    = '0;
    load[0] = in_fire;
    src[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = adv[k-1];
      src[k]  = data_q[k-1];
    end
  end

  // Next-state valids and their population count, so count tracks valid_q.
  always_comb begin
    valid_d = valid_q;
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush) begin
        valid_d[k] = 1'b0;
      end else if (load[k]) begin
        valid_d[k] = 1'b1;
      end else if (adv[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CNT_W'(valid_d[k]);
    end
  end

  // Valid bits and occupancy count; reset clears both.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Data registers load only when a word moves in; emptying never rewrites them.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      // NOTE: the data array is reset on purpose: out_data must read back
      // RESET_VALUE after reset, so these cannot be reset-less storage.
      if (!rst_n) begin
        data_q[k] <= RESET_VALUE;
      end else if (load[k] && !flush) begin
        data_q[k] <= src[k];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: four dff_pipe instances (DEPTH 3, 4, 2 and a 1-bit DEPTH 1)
// run directed scenarios then randomized traffic. A reference model keeps,
// per instance, an ordered list of in-flight words with their stage position
// and predicts in_ready before each edge and out_valid/out_data/count after it.
module tb_dff_pipe;

  localparam int NI = 4;

  typedef enum int { F_READY, F_VALID, F_DATA, F_COUNT } field_e;

  logic clk;
  logic       rst_n     [NI];
  logic       flush     [NI];
  logic       in_valid  [NI];
  logic [7:0] in_data   [NI];
  logic       out_ready [NI];

  logic       r0, r1, r2, r3;
  logic       v0, v1, v2, v3;
  logic [7:0] d0, d1, d2;
  logic       d3;
  logic [1:0] c0;
  logic [2:0] c1;
  logic [1:0] c2;
  logic       c3;

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) u_d3 (
    .clk(clk), .rst_n(rst_n[0]), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(r0), .in_data(in_data[0]),
    .out_valid(v0), .out_ready(out_ready[0]), .out_data(d0), .count(c0));

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'hA5)) u_d4 (
    .clk(clk), .rst_n(rst_n[1]), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(r1), .in_data(in_data[1]),
    .out_valid(v1), .out_ready(out_ready[1]), .out_data(d1), .count(c1));

  dff_pipe #(.WIDTH(8), .DEPTH(2), .RESET_VALUE(8'hA5)) u_d2 (
    .clk(clk), .rst_n(rst_n[2]), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_ready(r2), .in_data(in_data[2]),
    .out_valid(v2), .out_ready(out_ready[2]), .out_data(d2), .count(c2));

  dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n[3]), .flush(flush[3]),
    .in_valid(in_valid[3]), .in_ready(r3), .in_data(in_data[3][0:0]),
    .out_valid(v3), .out_ready(out_ready[3]), .out_data(d3), .count(c3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass, n_fail, n_total;
  bit armed;
  int cyc;

  // Reference model: in-flight words oldest first, with stage positions.
  int         m_cnt  [NI];
  logic [7:0] m_word [NI][4];
  int         m_pos  [NI][4];
  logic [7:0] m_last [NI];  // word held by the output stage's data register
  bit         m_acc  [NI];  // an input transfer happened at the last edge
  int         np_s   [4];
  bit         pop_s;

  // Emitted-word logs, captured from the DUT at each output transfer.
  logic [7:0] log_w [NI][64];
  int         log_n [NI];

  function automatic int dep(input int i);
    case (i)
      0: return 3;
      1: return 4;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] mask(input int i);
    return (i == 3) ? 8'h01 : 8'hFF;
  endfunction

  function automatic logic [7:0] rst_val(input int i);
    return (i == 3) ? 8'h01 : 8'hA5;
  endfunction

  function automatic logic [31:0] obs(input int i, input field_e f);
    logic [31:0] r;
    r = 'x;
    case (i)
      0: case (f) F_READY: r = {31'd0, r0}; F_VALID: r = {31'd0, v0};
                  F_DATA: r = {24'd0, d0};  default: r = {30'd0, c0}; endcase
      1: case (f) F_READY: r = {31'd0, r1}; F_VALID: r = {31'd0, v1};
                  F_DATA: r = {24'd0, d1};  default: r = {29'd0, c1}; endcase
      2: case (f) F_READY: r = {31'd0, r2}; F_VALID: r = {31'd0, v2};
                  F_DATA: r = {24'd0, d2};  default: r = {30'd0, c2}; endcase
      default: case (f) F_READY: r = {31'd0, r3}; F_VALID: r = {31'd0, v3};
                  F_DATA: r = {31'd0, d3};  default: r = {31'd0, c3}; endcase
    endcase
    return r;
  endfunction

  // Where each word lands this cycle: one step forward, never into or past
  // the slot its older neighbour ends up in; the head leaves if it sits in
  // the output stage and out_ready is high.
  function automatic void plan(input int i);
    int d, lim, first;
    d     = dep(i);
    lim   = d - 1;
    pop_s = (m_cnt[i] > 0) && (m_pos[i][0] == d - 1) && (out_ready[i] == 1'b1);
    first = pop_s ? 1 : 0;
    for (int j = 0; j < 4; j++) np_s[j] = 0;
    for (int j = first; j < m_cnt[i]; j++) begin
      np_s[j] = (m_pos[i][j] + 1 < lim) ? m_pos[i][j] + 1 : lim;
      lim     = np_s[j] - 1;
    end
  endfunction

  // Input accepted when stage 0 will be free after this cycle's moves.
  function automatic bit exp_ready(input int i);
    int n;
    plan(i);
    n = m_cnt[i] - (pop_s ? 1 : 0);
    if (flush[i] == 1'b1) return 1'b0;
    if (n == 0) return 1'b1;
    return np_s[m_cnt[i] - 1] >= 1;
  endfunction

  task automatic model_edge(input int i);
    bit acc;
    int k, first;
    acc = 1'b0;
    if (rst_n[i] == 1'b0) begin
      m_cnt[i]  = 0;
      m_last[i] = rst_val(i);
    end else if (flush[i] == 1'b1) begin
      m_cnt[i] = 0;
    end else begin
      acc   = (in_valid[i] == 1'b1) && exp_ready(i);
      plan(i);
      first = pop_s ? 1 : 0;
      k     = 0;
      for (int j = first; j < m_cnt[i]; j++) begin
        m_word[i][k] = m_word[i][j];
        m_pos[i][k]  = np_s[j];
        k++;
      end
      if (acc) begin
        m_word[i][k] = in_data[i] & mask(i);
        m_pos[i][k]  = 0;
        k++;
      end
      m_cnt[i] = k;
      if (k > 0 && m_pos[i][0] == dep(i) - 1) m_last[i] = m_word[i][0];
    end
    m_acc[i] = acc;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_total++;
    assert (observed === expected) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed 'h%0h expected 'h%0h",
             tag, cyc, observed, expected);
    end
  endtask

  // One clock cycle: entered just after a negedge with inputs already driven.
  task automatic tick();
    #1;
    for (int i = 0; i < NI; i++) begin
      if (armed) check($sformatf("in_ready[u%0d]", i), obs(i, F_READY),
                       {31'd0, exp_ready(i)});
      if (obs(i, F_VALID) == 32'd1 && out_ready[i] == 1'b1 && log_n[i] < 64) begin
        log_w[i][log_n[i]] = obs(i, F_DATA) & 32'hFF;
        log_n[i]++;
      end
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i);
    armed = 1'b1;
    cyc++;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("out_valid[u%0d]", i), obs(i, F_VALID),
            (m_cnt[i] > 0 && m_pos[i][0] == dep(i) - 1) ? 32'd1 : 32'd0);
      check($sformatf("out_data[u%0d]", i), obs(i, F_DATA), {24'd0, m_last[i]});
      check($sformatf("count[u%0d]", i), obs(i, F_COUNT), m_cnt[i]);
    end
    @(negedge clk);
  endtask

  task automatic push(input int i, input logic [7:0] w);
    in_valid[i] = 1'b1;
    in_data[i]  = w;
    tick();
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) log_n[i] = 0;
  endtask

  logic [7:0] acc_w [64];
  int         n_acc;

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0; armed = 1'b0; cyc = 0; n_acc = 0;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; flush[i] = 1'b0; in_valid[i] = 1'b0;
      in_data[i] = 8'h00; out_ready[i] = 1'b1; m_cnt[i] = 0;
      m_last[i] = 8'h00; m_acc[i] = 1'b0; log_n[i] = 0;
    end
    @(negedge clk);

    // Reset held for two cycles.
    tick(); tick();
    check("rst_out_valid", {31'd0, v0}, 32'd0);
    check("rst_out_data",  {24'd0, d0}, 32'hA5);
    check("rst_count",     {30'd0, c0}, 32'd0);
    check("rst_in_ready",  {31'd0, r0}, 32'd1);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    tick();

    // Streaming through DEPTH 3 with out_ready held high.
    clear_logs();
    for (int v = 1; v <= 16; v++) push(0, 8'(v));
    in_valid[0] = 1'b0;
    repeat (4) tick();
    check("stream_count", log_n[0], 32'd16);
    for (int v = 1; v <= 16; v++)
      check($sformatf("stream_word%0d", v), {24'd0, log_w[0][v-1]}, v);

    // Backpressure and bubble collapse on DEPTH 3.
    clear_logs();
    out_ready[0] = 1'b0;
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    in_valid[0] = 1'b0;
    #1;
    check("bp_full_in_ready", {31'd0, r0}, 32'd0);
    check("bp_full_count",    {30'd0, c0}, 32'd3);
    in_valid[0] = 1'b1; in_data[0] = 8'h44; out_ready[0] = 1'b1;
    #1;
    check("bp_swap_in_ready", {31'd0, r0}, 32'd1);
    tick();
    check("bp_swap_count", {30'd0, c0}, 32'd3);
    in_valid[0] = 1'b0;
    repeat (4) tick();
    check("bp_drain_n", log_n[0], 32'd4);
    check("bp_word0", {24'd0, log_w[0][0]}, 32'h11);
    check("bp_word1", {24'd0, log_w[0][1]}, 32'h22);
    check("bp_word2", {24'd0, log_w[0][2]}, 32'h33);
    check("bp_word3", {24'd0, log_w[0][3]}, 32'h44);

    // Flush on DEPTH 4 with an input offered in the same cycle.
    clear_logs();
    out_ready[1] = 1'b0;
    push(1, 8'h61); push(1, 8'h62); push(1, 8'h63);
    in_data[1] = 8'h77; flush[1] = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, r1}, 32'd0);
    tick();
    check("flush_count", {29'd0, c1}, 32'd0);
    check("flush_out_valid", {31'd0, v1}, 32'd0);
    flush[1] = 1'b0; in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    repeat (6) tick();
    check("flush_nothing_emitted", log_n[1], 32'd0);

    // Reset pulse mid-stream on DEPTH 2.
    out_ready[2] = 1'b0;
    push(2, 8'hA1); push(2, 8'hA2);
    in_valid[2] = 1'b0;
    check("mid_full_count", {30'd0, c2}, 32'd2);
    rst_n[2] = 1'b0;
    tick();
    check("mid_rst_out_valid", {31'd0, v2}, 32'd0);
    check("mid_rst_out_data",  {24'd0, d2}, 32'hA5);
    check("mid_rst_count",     {30'd0, c2}, 32'd0);
    rst_n[2] = 1'b1;
    push(2, 8'h5A);
    in_valid[2] = 1'b0; out_ready[2] = 1'b1;
    check("mid_latency_not_yet", {31'd0, v2}, 32'd0);
    tick();
    check("mid_emit_valid", {31'd0, v2}, 32'd1);
    check("mid_emit_data",  {24'd0, d2}, 32'h5A);
    tick();

    // DEPTH 1, WIDTH 1: continuous in_valid, out_ready alternating.
    clear_logs();
    in_valid[3] = 1'b1;
    in_data[3]  = 8'($urandom_range(1, 0));
    for (int c = 0; c < 12; c++) begin
      out_ready[3] = c[0];
      tick();
      if (m_acc[3]) begin
        acc_w[n_acc] = in_data[3];
        n_acc++;
        in_data[3] = 8'($urandom_range(1, 0));
      end
    end
    in_valid[3] = 1'b0; out_ready[3] = 1'b1;
    repeat (2) tick();
    check("d1_accepted", n_acc, 32'd7);
    check("d1_emitted", log_n[3], n_acc);
    for (int k = 0; k < n_acc; k++)
      check($sformatf("d1_bit%0d", k), {24'd0, log_w[3][k]}, {24'd0, acc_w[k]});

    // Randomized traffic on all instances, honouring the input hold rule.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (in_valid[i] == 1'b0 || m_acc[i]) begin
          in_valid[i] = ($urandom_range(2, 0) != 0);
          in_data[i]  = 8'($urandom);
        end
        out_ready[i] = ($urandom_range(3, 0) != 0);
        flush[i]     = ($urandom_range(15, 0) == 0);
        rst_n[i]     = ($urandom_range(63, 0) != 0);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
